// File: rtl/cve2_mem_arbiter.sv
// Round-robin 2:1 arbiter of core fetch/data ports onto one single-port SRAM with 1-cycle read latency.
// Grant is combinational; rvalid follows each grant one cycle later; optional CVE2_MEM_RANGE_CHECK_EN returns bus errors.
module cve2_mem_arbiter #(
   parameter int unsigned MemAw   = 14,
   parameter logic [31:0] MemBase = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             instr_req_i,
   output logic             instr_gnt_o,
   input  logic [31:0]      instr_addr_i,
   output logic             instr_rvalid_o,
   output logic [31:0]      instr_rdata_o,
   output logic             instr_err_o,
   input  logic             data_req_i,
   output logic             data_gnt_o,
   input  logic             data_we_i,
   input  logic [3:0]       data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [31:0]      data_wdata_i,
   output logic             data_rvalid_o,
   output logic [31:0]      data_rdata_o,
   output logic             data_err_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic [MemAw-1:0] mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i
);

   typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_e;

   port_e       r_last;
   port_e       r_rsp_port;
   logic        r_rsp_valid;
   logic        r_rsp_we;
   logic        w_instr_gnt;
   logic        w_data_gnt;
   logic        w_gnt;
   logic        w_in_range;
   logic        w_rsp_err;
   logic        w_rsp_read;
   logic [31:0] w_addr;
   logic        w_unused;

   // Grants are gated by rst_ni so nothing is issued while the core is held in reset.
   assign w_data_gnt  = rst_ni & data_req_i & ~(instr_req_i & (r_last == PORT_DATA));
   assign w_instr_gnt = rst_ni & instr_req_i & ~w_data_gnt;
   assign w_gnt       = w_instr_gnt | w_data_gnt;
   assign w_addr      = w_data_gnt ? data_addr_i : instr_addr_i;

   assign instr_gnt_o = w_instr_gnt;
   assign data_gnt_o  = w_data_gnt;

   assign mem_req_o   = w_gnt & w_in_range;
   assign mem_we_o    = w_data_gnt & data_we_i & w_in_range;
   assign mem_be_o    = w_data_gnt ? data_be_i : (w_instr_gnt ? 4'hF : 4'h0);
   assign mem_addr_o  = w_gnt ? w_addr[MemAw+1:2] : '0;
   assign mem_wdata_o = w_data_gnt ? data_wdata_i : 32'h0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last      <= PORT_INSTR;
         r_rsp_valid <= 1'b0;
         r_rsp_port  <= PORT_INSTR;
         r_rsp_we    <= 1'b0;
      end else begin
         r_rsp_valid <= w_gnt;
         if (w_gnt) begin
            r_last     <= w_data_gnt ? PORT_DATA : PORT_INSTR;
            r_rsp_port <= w_data_gnt ? PORT_DATA : PORT_INSTR;
            r_rsp_we   <= w_data_gnt & data_we_i;
         end
      end
   end

`ifdef CVE2_MEM_RANGE_CHECK_EN
   localparam logic [31:0] RangeMask = ~((32'd1 << (MemAw + 2)) - 32'd1);
   logic r_rsp_err;

   // Out-of-range requests are granted but never reach the SRAM.
   assign w_in_range = ((w_addr & RangeMask) == (MemBase & RangeMask));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_err <= 1'b0;
      end else if (w_gnt) begin
         r_rsp_err <= ~w_in_range;
      end
   end

   assign w_rsp_err = r_rsp_err;
`else
   assign w_in_range = 1'b1;
   assign w_rsp_err  = 1'b0;
`endif

   // Response steering depends only on registered state; mem_rdata_i is a pure data path.
   assign w_rsp_read     = r_rsp_valid & ~r_rsp_we & ~w_rsp_err;
   assign instr_rvalid_o = r_rsp_valid & (r_rsp_port == PORT_INSTR);
   assign data_rvalid_o  = r_rsp_valid & (r_rsp_port == PORT_DATA);
   assign instr_err_o    = instr_rvalid_o & w_rsp_err;
   assign data_err_o     = data_rvalid_o & w_rsp_err;
   assign instr_rdata_o  = (w_rsp_read & (r_rsp_port == PORT_INSTR)) ? mem_rdata_i : 32'h0;
   assign data_rdata_o   = (w_rsp_read & (r_rsp_port == PORT_DATA)) ? mem_rdata_i : 32'h0;

   assign w_unused = ^{instr_addr_i, data_addr_i, MemBase};

endmodule

// File: doc/cve2_mem_arbiter.md
# cve2_mem_arbiter

Two-to-one memory arbiter directly downstream of the core top level: it accepts the core's instruction-fetch and data request/grant/rvalid ports and serialises them onto one single-port SRAM with fixed one-cycle read latency. It gives the small-footprint CVE2 configuration a single tightly-coupled memory without an interconnect. Conflicts are resolved round-robin. An optional address-range check returns bus errors instead of aliasing.

## Interface
Parameters:
- MemAw, 14: SRAM word-address width. Memory spans 4·2^MemAw bytes.
- MemBase, 32'h0000_0000: byte base address of the SRAM. Must be aligned to the memory size.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request. Held until granted.
- instr_gnt_o  out  1  fetch grant
- instr_addr_i  in  32  fetch byte address. Bits [1:0] are ignored.
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
- data_req_i  in  1  data request. Held until granted.
- data_gnt_o  out  1  data grant
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address. Bits [1:0] are ignored.
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error, qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MemAw  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o

## Operation
- At most one grant per cycle. A grant is issued in the same cycle as its request, so the grant is combinational from the requests.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port other than last_q is granted.
  - last_q records the most recently granted port and updates on every grant. Its reset value is instr, so the first conflict goes to data.
- Granted request:
  - mem_req_o=1.
  - mem_addr_o = address[MemAw+1:2].
  - mem_we_o/mem_be_o/mem_wdata_o come from the data port when data is granted; otherwise mem_we_o=0 and mem_be_o=4'hF.
- Response registers, all reset to 0:
  - rsp_valid_q, rsp_port_q, rsp_we_q, rsp_err_q are loaded on every grant.
  - rsp_valid_q clears when there is no grant.
- Response outputs:
  - instr_rvalid_o = rsp_valid_q & (rsp_port_q==instr); data_rvalid_o likewise for data.
  - rdata = mem_rdata_i for a valid non-error read; 0 for writes, errors and idle cycles.
- The owner of a response is fixed at grant time. mem_rdata_i is steered only to that port, and the other port's rvalid stays 0.
- Back-to-back grants are legal every cycle, including alternating ports. There is no bubble.
- Reset asserted mid-operation: any pending response is discarded, and no rvalid is emitted after reset is released.
- Non-granted memory outputs are driven to 0 (mem_req_o=0, mem_we_o=0).

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to rvalid: exactly 1 cycle, for reads, writes and errors alike.
- Outputs during and immediately after reset: all gnt, rvalid, err, rdata and mem_* outputs are 0.
- No combinational path from any response input to any grant output.
- mem_rdata_i feeds the rdata outputs combinationally through a mux selected only by registered state.

## Configuration
- CVE2_MEM_RANGE_CHECK_EN defined:
  - A granted request whose address lies outside [MemBase, MemBase+4·2^MemAw) still receives a grant.
  - It does not assert mem_req_o, so no SRAM read or write occurs.
  - It returns rvalid with err=1 and rdata=0 one cycle later.
- CVE2_MEM_RANGE_CHECK_EN undefined:
  - Upper address bits are ignored and addresses alias into the SRAM.
  - err outputs are tied to 0, and rsp_err_q is not implemented.

## Test plan
- Single fetch to 0x0000_0010 with the SRAM word 4 = 0xDEAD_BEEF:
  - instr_gnt_o=1 in the same cycle, mem_addr_o=4.
  - Next cycle: instr_rvalid_o=1, instr_rdata_o=0xDEAD_BEEF, data_rvalid_o=0.
- Simultaneous instr and data requests held for 4 cycles after reset:
  - Grants go data, instr, data, instr.
  - Each rvalid arrives on the correct port one cycle after its grant.
- Data write to 0x0000_0100 with be=4'b0011, wdata=0x1234_5678, followed by a read of the same address:
  - mem_we_o=1 and mem_be_o=4'b0011 on the write.
  - The write's rvalid carries rdata=0.
  - The read returns the SRAM-merged value.
- With CVE2_MEM_RANGE_CHECK_EN and MemAw=14, a data read of 0x0001_0000:
  - gnt=1, mem_req_o=0.
  - Next cycle: data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
  - Without the macro: SRAM word 0 is accessed and err=0.
- rst_ni pulsed low in the cycle after a data grant:
  - data_rvalid_o stays 0 and all outputs are 0 during reset.
  - The first conflict after reset is granted to data.
- 100 cycles of random requests on both ports:
  - Grant count per port equals rvalid count per port.
  - There is never more than one grant per cycle.
  - Neither port waits more than 1 cycle while the other port is requesting.
